tile_scene_streamer: RTL and testbench
======================================

// Module: tile_scene_streamer
// PURPOSE
//  Parametrised maze-scene streamer. Rasterises a COLS x ROWS grid of square tiles with
//  wall segments into a byte stream for the TFT byte transmitter. Runs after tft_init
//  finishes; tft_dc is held at 1 (DATA) externally. Successor to the fixed 10x15 streamer:
//  configurable geometry and colour depth, and a start/done handshake. Wall maps are
//  snapshotted at start, so a frame never tears.
// PARAMETERS
//  COLS        10         tiles per row
//  ROWS        15         tiles per column
//  TILE_SHIFT  5          tile edge = 1<<TILE_SHIFT pixels
//  WALL_THICK  2          wall thickness in pixels, 1..(tile/2)
//  BPP         3          bytes per pixel, 1..3, sent MSB first (R,G,B)
//  WALL_RGB    24'h3a7bd5 wall colour; byte k of a pixel = WALL_RGB[23-8k -: 8]
//  BG_RGB      24'h000000 background colour, same byte rule as WALL_RGB
// PORTS
//  clk           in   1                clock
//  rst           in   1                asynchronous reset, active-high
//  start         in   1                one-cycle request for one frame; ignored while busy=1
//  v_walls       in   ROWS*(COLS-1)    bit r*(COLS-1)+c: wall between tile (c,r) and tile (c+1,r)
//  h_walls       in   (ROWS-1)*COLS    bit r*COLS+c: wall between tile (c,r) and tile (c,r+1)
//  food          in   ROWS*COLS        bit r*COLS+c: food in tile (c,r). Present only with SCENE_FOOD_EN
//  tft_busy      in   1                transmitter busy
//  tft_data      out  8                byte to send
//  tft_transmit  out  1                one-cycle send strobe
//  busy          out  1                frame in progress
//  done          out  1                one-cycle pulse at frame end
// BEHAVIOUR
//  Reset values: tft_data=0, tft_transmit=0, busy=0, done=0, FSM=IDLE, counters=0.
//  FSM states:
//  - IDLE: start=1 latches v_walls/h_walls (and food) into shadow registers, clears x, y
//    and byte counters, then -> CALC. busy=1 from the next cycle until IDLE is re-entered.
//  - CALC: register the colour of pixel (x,y) from the shadow maps, then -> SEND.
//  - SEND: while tft_busy=1, stay. When tft_busy=0: drive tft_data = colour byte bidx,
//    pulse tft_transmit for exactly 1 cycle, then -> HOLD.
//  - HOLD: ignore tft_busy for exactly 1 cycle, which covers the transmitter's busy latency.
//    Then advance:
//    - bidx<BPP-1: bidx++ -> SEND.
//    - Otherwise bidx=0 and x++.
//    - On x wrap: x=0, y++.
//    - After the last pixel (x=COLS*tile-1, y=ROWS*tile-1): -> IDLE, done=1 for 1 cycle.
//    - Otherwise -> CALC.
//  tft_data holds its last value between strobes.
//  Raster order: row-major, y outer, from pixel (0,0) to (COLS*tile-1, ROWS*tile-1).
//  Total strobes per frame = COLS*ROWS*tile^2*BPP.
//  Pixel classification, with tile c=x>>TILE_SHIFT, r=y>>TILE_SHIFT, local offsets lx, ly:
//  - Wall if lx<WALL_THICK and (c==0 or left wall set).
//  - Wall if lx>=tile-WALL_THICK and (c==COLS-1 or right wall set).
//  - Top and bottom edges use the same rules on ly, with r==0 / r==ROWS-1 as outer edges.
//  - Wall if the pixel is in any WALL_THICK square corner post (always drawn).
//  - Outer grid border is always wall.
//  Widths: x counter clog2(COLS<<TILE_SHIFT), y counter clog2(ROWS<<TILE_SHIFT),
//  bidx counter 2 bits. No arithmetic overflow is allowed; tile indices come from bit slices.
//  start while busy=1: ignored; no queuing. start on the same cycle as done: accepted (FSM is IDLE).
//  rst mid-frame: immediate return to IDLE, all outputs return to reset values, no done pulse.
//  Input map changes during a frame have no effect until the next start.
// CONFIGURATION
//  SCENE_FOOD_EN defined:
//  - The food port exists and is snapshotted at start.
//  - A non-wall pixel inside the centred square of side tile/4 in a food tile takes the
//    colour FOOD_RGB from the shared include.
//  SCENE_FOOD_EN undefined: no food port or shadow register; only walls and background are drawn.
// STRUCTURE
//  - scene_defs.vh: FSM state encodings (IDLE/CALC/SEND/HOLD), FOOD_RGB, default colours.
//  - tile_wall_mask: combinational sub-module. Inputs: lx, ly, four edge flags, optional food
//    flag. Output: 2-bit pixel class (BG/WALL/FOOD). This module registers the class in CALC.
//  - This module: FSM, counters, shadow maps, byte select.
// TESTING
//  Most tests use COLS=2, ROWS=2, TILE_SHIFT=2, WALL_THICK=1, BPP=1 (64 strobes per frame).
//  1. All walls 0, tft_busy tied 0, start -> 64 strobes. Pixel (1,1)=BG_RGB[23:16].
//     Pixel (0,0)=8'h3a (corner). Pixel (4,1)=BG, because the internal edge is open.
//     done pulses once, 1 cycle after the HOLD of strobe 64.
//  2. v_walls=1'b1 on row 0 -> pixels (3,1) and (4,1) are 8'h3a. Pixel (3,5) is BG.
//  3. BPP=3, same frame -> 192 strobes; wall pixel bytes 3a,7b,d5 in order.
//  4. tft_busy high for 5 cycles after each strobe -> no strobe while busy=1.
//     Byte sequence identical to test 1.
//  5. start pulsed again at strobe 10, and v_walls toggled mid-frame ->
//     exactly 64 strobes and the output equals the frame snapshotted at start.
//     rst at strobe 20 -> busy=0 and tft_transmit=0 at once, with no done pulse.
//  6. With SCENE_FOOD_EN, food=4'b0001 -> pixel (2,2) has colour FOOD_RGB; tile (1,0) has none.

Source files
------------

// File: rtl/tile_scene_streamer_pkg.sv
// Shared definitions for the maze-scene streamer: FSM states, pixel classes and colours.
// FOOD_RGB is only drawn when the design is built with SCENE_FOOD_EN defined.
package tile_scene_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PIX_BG   = 2'd0,
        PIX_WALL = 2'd1,
        PIX_FOOD = 2'd2
    } pix_class_t;

    localparam logic [23:0] FOOD_RGB         = 24'hf2c94c;
    localparam logic [23:0] WALL_RGB_DEFAULT = 24'h3a7bd5;
    localparam logic [23:0] BG_RGB_DEFAULT   = 24'h000000;

    // Byte k of a pixel colour, most significant (red) byte first.
    function automatic logic [7:0] rgb_byte(input logic [23:0] rgb, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = rgb[23:16];
            2'd1:    b = rgb[15:8];
            2'd2:    b = rgb[7:0];
            default: b = rgb[23:16];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tile_scene_streamer_wall_mask.sv
// Combinational pixel classifier for one tile: wall edges, corner posts and (with
// SCENE_FOOD_EN) the centred food square.
module tile_scene_streamer_wall_mask
    import tile_scene_streamer_pkg::*;
#(
    parameter int TILE_SHIFT = 5,
    parameter int WALL_THICK = 2
) (
    input  logic [TILE_SHIFT-1:0] lx,
    input  logic [TILE_SHIFT-1:0] ly,
    input  logic                  edge_left,
    input  logic                  edge_right,
    input  logic                  edge_top,
    input  logic                  edge_bottom,
`ifdef SCENE_FOOD_EN
    input  logic                  food,
`endif
    output pix_class_t            pix_class
);

    localparam int TILE = 1 << TILE_SHIFT;
    localparam logic [TILE_SHIFT-1:0] LO_LIMIT = TILE_SHIFT'(WALL_THICK);
    localparam logic [TILE_SHIFT-1:0] HI_LIMIT = TILE_SHIFT'(TILE - WALL_THICK);
    // Food square of side tile/4 starting at tile/2 - tile/8, so it stays centred for any tile size.
    localparam logic [TILE_SHIFT-1:0] FOOD_LO  = TILE_SHIFT'((TILE >> 1) - (TILE >> 3));
    localparam logic [TILE_SHIFT-1:0] FOOD_HI  = TILE_SHIFT'((TILE >> 1) - (TILE >> 3) + (TILE >> 2));

    logic lx_lo_s, lx_hi_s, ly_lo_s, ly_hi_s, wall_s, food_hit_s;

    assign lx_lo_s = (lx < LO_LIMIT);
    assign lx_hi_s = (lx >= HI_LIMIT);
    assign ly_lo_s = (ly < LO_LIMIT);
    assign ly_hi_s = (ly >= HI_LIMIT);

    // Corner posts are drawn regardless of the edge flags.
    assign wall_s = (lx_lo_s && edge_left) || (lx_hi_s && edge_right) ||
                    (ly_lo_s && edge_top)  || (ly_hi_s && edge_bottom) ||
                    ((lx_lo_s || lx_hi_s) && (ly_lo_s || ly_hi_s));

`ifdef SCENE_FOOD_EN
    assign food_hit_s = food && (lx >= FOOD_LO) && (lx < FOOD_HI) &&
                        (ly >= FOOD_LO) && (ly < FOOD_HI);
`else
    assign food_hit_s = 1'b0;
`endif

    // Walls take priority over food.
    always_comb begin
        pix_class = PIX_BG;
        if (wall_s) begin
            pix_class = PIX_WALL;
        end else if (food_hit_s) begin
            pix_class = PIX_FOOD;
        end else begin
            pix_class = PIX_BG;
        end
    end

endmodule

// File: rtl/tile_scene_streamer.sv
// Maze-scene streamer: rasterises a COLS x ROWS tile grid with walls into TFT data bytes,
// one frame per start. Define SCENE_FOOD_EN to add the food map and food markers.
module tile_scene_streamer
    import tile_scene_streamer_pkg::*;
#(
    parameter int          COLS       = 10,
    parameter int          ROWS       = 15,
    parameter int          TILE_SHIFT = 5,
    parameter int          WALL_THICK = 2,
    parameter int          BPP        = 3,
    parameter logic [23:0] WALL_RGB   = WALL_RGB_DEFAULT,
    parameter logic [23:0] BG_RGB     = BG_RGB_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROWS*(COLS-1)-1:0] v_walls,
    input  logic [(ROWS-1)*COLS-1:0] h_walls,
`ifdef SCENE_FOOD_EN
    input  logic [ROWS*COLS-1:0]     food,
`endif
    input  logic                     tft_busy,
    output logic [7:0]               tft_data,
    output logic                     tft_transmit,
    output logic                     busy,
    output logic                     done
);

    localparam int XW = $clog2(COLS << TILE_SHIFT);
    localparam int YW = $clog2(ROWS << TILE_SHIFT);
    localparam int VW = ROWS * (COLS - 1);
    localparam int HW = (ROWS - 1) * COLS;
    localparam logic [XW-1:0] X_LAST = XW'((COLS << TILE_SHIFT) - 1);
    localparam logic [YW-1:0] Y_LAST = YW'((ROWS << TILE_SHIFT) - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1'b1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1'b1);
    localparam logic [1:0]    B_LAST = 2'(BPP - 1);
    localparam logic [VW-1:0] V_ONE  = VW'(1'b1);
    localparam logic [HW-1:0] H_ONE  = HW'(1'b1);

    state_t            state_r, next_state_s;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [1:0]        bidx_r;
    logic [VW-1:0]     v_sh_r;
    logic [HW-1:0]     h_sh_r;
    logic [23:0]       colour_r;
    logic [7:0]        tft_data_r, data_s;
    logic              tft_transmit_r, transmit_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              frame_end_s;
    int                col_s, row_s;
    logic              edge_left_s, edge_right_s, edge_top_s, edge_bottom_s;
    pix_class_t        pix_class_s;
`ifdef SCENE_FOOD_EN
    localparam int FW = ROWS * COLS;
    localparam logic [FW-1:0] F_ONE = FW'(1'b1);
    logic [FW-1:0]     food_sh_r;
    logic              food_flag_s;
`endif

    assign frame_end_s = (bidx_r == B_LAST) && (x_r == X_LAST) && (y_r == Y_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; HOLD always lasts exactly one cycle and never samples tft_busy.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: if (start) next_state_s = ST_CALC; else next_state_s = ST_IDLE;
            ST_CALC: next_state_s = ST_SEND;
            ST_SEND: if (tft_busy) next_state_s = ST_SEND; else next_state_s = ST_HOLD;
            ST_HOLD: begin
                if (bidx_r != B_LAST) begin
                    next_state_s = ST_SEND;
                end else if (frame_end_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; tft_data keeps its last byte between strobes.
    always_comb begin
        transmit_s = 1'b0;
        done_s     = 1'b0;
        data_s     = tft_data_r;
        case (state_r)
            ST_SEND: begin
                if (!tft_busy) begin
                    transmit_s = 1'b1;
                    data_s     = rgb_byte(colour_r, bidx_r);
                end else begin
                    transmit_s = 1'b0;
                end
            end
            ST_HOLD: if (frame_end_s) done_s = 1'b1; else done_s = 1'b0;
            default: transmit_s = 1'b0;
        endcase
        busy_s = (next_state_s != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tft_data_r     <= 8'h00;
            tft_transmit_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            tft_data_r     <= data_s;
            tft_transmit_r <= transmit_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
        end
    end

    assign tft_data     = tft_data_r;
    assign tft_transmit = tft_transmit_r;
    assign busy         = busy_r;
    assign done         = done_r;

    // Raster counters: byte index innermost, then x, then y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r    <= '0;
            y_r    <= '0;
            bidx_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        x_r    <= '0;
                        y_r    <= '0;
                        bidx_r <= 2'd0;
                    end
                end
                ST_HOLD: begin
                    if (bidx_r != B_LAST) begin
                        bidx_r <= bidx_r + 2'd1;
                    end else begin
                        bidx_r <= 2'd0;
                        if (x_r == X_LAST) begin
                            x_r <= '0;
                            y_r <= (y_r == Y_LAST) ? '0 : y_r + Y_ONE;
                        end else begin
                            x_r <= x_r + X_ONE;
                        end
                    end
                end
                default: bidx_r <= bidx_r;
            endcase
        end
    end

    // Shadow maps are captured only when a frame is accepted, so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sh_r <= '0;
            h_sh_r <= '0;
`ifdef SCENE_FOOD_EN
            food_sh_r <= '0;
`endif
        end else if (state_r == ST_IDLE && start) begin
            v_sh_r <= v_walls;
            h_sh_r <= h_walls;
`ifdef SCENE_FOOD_EN
            food_sh_r <= food;
`endif
        end
    end

    // Edge flags of the current tile; outer grid edges are always walls.
    always_comb begin
        col_s = int'(x_r[XW-1:TILE_SHIFT]);
        row_s = int'(y_r[YW-1:TILE_SHIFT]);
        edge_left_s   = (col_s == 32'sd0) ||
            |(v_sh_r & (V_ONE << (row_s * (COLS - 1) + ((col_s > 32'sd0) ? col_s - 32'sd1 : 32'sd0))));
        edge_right_s  = (col_s == COLS - 1) ||
            |(v_sh_r & (V_ONE << (row_s * (COLS - 1) + ((col_s < COLS - 1) ? col_s : 32'sd0))));
        edge_top_s    = (row_s == 32'sd0) ||
            |(h_sh_r & (H_ONE << (((row_s > 32'sd0) ? row_s - 32'sd1 : 32'sd0) * COLS + col_s)));
        edge_bottom_s = (row_s == ROWS - 1) ||
            |(h_sh_r & (H_ONE << (((row_s < ROWS - 1) ? row_s : 32'sd0) * COLS + col_s)));
`ifdef SCENE_FOOD_EN
        food_flag_s   = |(food_sh_r & (F_ONE << (row_s * COLS + col_s)));
`endif
    end

    tile_scene_streamer_wall_mask #(
        .TILE_SHIFT (TILE_SHIFT),
        .WALL_THICK (WALL_THICK)
    ) u_mask (
        .lx          (x_r[TILE_SHIFT-1:0]),
        .ly          (y_r[TILE_SHIFT-1:0]),
        .edge_left   (edge_left_s),
        .edge_right  (edge_right_s),
        .edge_top    (edge_top_s),
        .edge_bottom (edge_bottom_s),
`ifdef SCENE_FOOD_EN
        .food        (food_flag_s),
`endif
        .pix_class   (pix_class_s)
    );

    // Pixel colour is latched in CALC and held for all of the pixel's bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour_r <= 24'h000000;
        end else if (state_r == ST_CALC) begin
            case (pix_class_s)
                PIX_WALL: colour_r <= WALL_RGB;
                PIX_FOOD: colour_r <= FOOD_RGB;
                default:  colour_r <= BG_RGB;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_scene_streamer.sv
// Directed bench for tile_scene_streamer on a 2x2 grid of 4-pixel tiles (BPP=1 and BPP=3).
// Build with SCENE_FOOD_EN defined to also cover the food marker.
module tb_tile_scene_streamer;
    import tile_scene_streamer_pkg::*;

    typedef struct {
        logic [1:0] v;
        logic [1:0] h;
        int         x;
        int         y;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic       clk, rst, start1, start3, tft_busy1, tft_busy3;
    logic [1:0] v_walls, h_walls;
    logic [7:0] data1, data3;
    logic       xmit1, xmit3, busy1, busy3, done1, done3;
`ifdef SCENE_FOOD_EN
    logic [3:0] food;
`endif

    int         errors = 0;
    int         checks = 0;
    int         n_strobe, n_done, busy_viol, done_cyc, last_strobe_cyc;
    logic [7:0] frame [192];
    logic [7:0] ref0  [64];
    vec_t       vecs  [14];

    tile_scene_streamer #(.COLS(2), .ROWS(2), .TILE_SHIFT(2), .WALL_THICK(1), .BPP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .v_walls(v_walls), .h_walls(h_walls),
`ifdef SCENE_FOOD_EN
        .food(food),
`endif
        .tft_busy(tft_busy1), .tft_data(data1), .tft_transmit(xmit1), .busy(busy1), .done(done1));

    tile_scene_streamer #(.COLS(2), .ROWS(2), .TILE_SHIFT(2), .WALL_THICK(1), .BPP(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .v_walls(v_walls), .h_walls(h_walls),
`ifdef SCENE_FOOD_EN
        .food(food),
`endif
        .tft_busy(tft_busy3), .tft_data(data3), .tft_transmit(xmit3), .busy(busy3), .done(done3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Runs one frame on the selected DUT, capturing strobed bytes into frame[].
    task automatic run_frame(input bit sel, input bit busy_mode, input int restart_at,
                             input int flip_at, input int rst_at);
        int  busy_cnt;
        bit  xm, dn, finished, rst_hit;
        busy_cnt = 0; n_strobe = 0; n_done = 0; busy_viol = 0;
        done_cyc = -1; last_strobe_cyc = -1; finished = 1'b0; rst_hit = 1'b0;
        for (int i = 0; i < 192; i++) frame[i] = 8'h55;
        @(negedge clk);
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start1 = 1'b0; start3 = 1'b0;
            xm = sel ? xmit3 : xmit1;
            dn = sel ? done3 : done1;
            if (xm) begin
                if (tft_busy1) busy_viol++;
                if (n_strobe < 192) frame[n_strobe] = sel ? data3 : data1;
                n_strobe++;
                last_strobe_cyc = cyc;
            end
            if (dn) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy_mode) begin
                if (xm) busy_cnt = 5;
                else if (busy_cnt > 0) busy_cnt--;
                tft_busy1 = (busy_cnt > 0);
            end
            if (xm && n_strobe == restart_at) begin
                if (sel) start3 = 1'b1; else start1 = 1'b1;
            end
            if (xm && n_strobe == flip_at) v_walls = ~v_walls;
            if (xm && n_strobe == rst_at) begin
                rst = 1'b1;
                #1;
                check_val("rst_mid_busy", busy1, 0);
                check_val("rst_mid_xmit", xmit1, 0);
                check_val("rst_mid_done", done1, 0);
                rst_hit = 1'b1; finished = 1'b1;
                break;
            end
            if (dn) begin
                finished = 1'b1;
                break;
            end
        end
        tft_busy1 = 1'b0;
        check_val("frame_finished", finished, 1);
        if (rst_hit) begin
            @(negedge clk);
            rst = 1'b0;
        end
        // Trailing window: no further strobes or done pulses may appear.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sel ? xmit3 : xmit1) n_strobe++;
            if (sel ? done3 : done1) n_done++;
        end
    endtask

    task automatic compare_ref(input string nm);
        int mm;
        mm = 0;
        for (int i = 0; i < 64; i++) if (frame[i] !== ref0[i]) mm++;
        check_val(nm, mm, 0);
    endtask

    initial begin
        logic [23:0] food_rgb_v;
        food_rgb_v = FOOD_RGB;
        vecs[0]  = '{2'b00, 2'b00, 1, 1, 8'h00, "bg_inner"};
        vecs[1]  = '{2'b00, 2'b00, 0, 0, 8'h3a, "corner_00"};
        vecs[2]  = '{2'b00, 2'b00, 4, 1, 8'h00, "open_inner_edge"};
        vecs[3]  = '{2'b00, 2'b00, 7, 5, 8'h3a, "right_border"};
        vecs[4]  = '{2'b00, 2'b00, 3, 3, 8'h3a, "centre_post"};
        vecs[5]  = '{2'b00, 2'b00, 6, 7, 8'h3a, "bottom_border"};
        vecs[6]  = '{2'b01, 2'b00, 3, 1, 8'h3a, "vwall_left_side"};
        vecs[7]  = '{2'b01, 2'b00, 4, 1, 8'h3a, "vwall_right_side"};
        vecs[8]  = '{2'b01, 2'b00, 3, 5, 8'h00, "vwall_row1_open"};
        vecs[9]  = '{2'b00, 2'b10, 5, 3, 8'h3a, "hwall_upper_side"};
        vecs[10] = '{2'b00, 2'b10, 5, 4, 8'h3a, "hwall_lower_side"};
        vecs[11] = '{2'b00, 2'b10, 1, 3, 8'h00, "hwall_col0_open"};
        vecs[12] = '{2'b10, 2'b00, 3, 5, 8'h3a, "vwall_row1_set"};
        vecs[13] = '{2'b10, 2'b00, 3, 1, 8'h00, "vwall_row0_open"};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; tft_busy1 = 1'b0; tft_busy3 = 1'b0;
        v_walls = 2'b00; h_walls = 2'b00;
`ifdef SCENE_FOOD_EN
        food = 4'b0000;
`endif
        #1;
        check_val("reset_data", data1, 0);
        check_val("reset_xmit", xmit1, 0);
        check_val("reset_busy", busy1, 0);
        check_val("reset_done", done1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Baseline frame: open grid, transmitter always ready.
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check_val("base_strobes", n_strobe, 64);
        check_val("base_done_count", n_done, 1);
        check_val("base_done_timing", done_cyc, last_strobe_cyc + 1);
        for (int i = 0; i < 64; i++) ref0[i] = frame[i];

        // Table of pixels; a new frame is run whenever the wall configuration changes.
        for (int i = 0; i < 14; i++) begin
            if (i == 0 || vecs[i].v != vecs[i-1].v || vecs[i].h != vecs[i-1].h) begin
                v_walls = vecs[i].v;
                h_walls = vecs[i].h;
                run_frame(1'b0, 1'b0, -1, -1, -1);
                check_val("table_strobes", n_strobe, 64);
            end
            check_val(vecs[i].name, frame[vecs[i].y * 8 + vecs[i].x], vecs[i].exp);
        end
        v_walls = 2'b00; h_walls = 2'b00;

        // Three bytes per pixel, red first.
        run_frame(1'b1, 1'b0, -1, -1, -1);
        check_val("bpp3_strobes", n_strobe, 192);
        check_val("bpp3_done_count", n_done, 1);
        check_val("bpp3_p00_r", frame[0], 8'h3a);
        check_val("bpp3_p00_g", frame[1], 8'h7b);
        check_val("bpp3_p00_b", frame[2], 8'hd5);
        check_val("bpp3_p11_g", frame[28], 8'h00);
        check_val("bpp3_p77_b", frame[191], 8'hd5);
        check_val("bpp3_done_timing", done_cyc, last_strobe_cyc + 1);

        // Transmitter busy for 5 cycles after every strobe.
        run_frame(1'b0, 1'b1, -1, -1, -1);
        check_val("busy_strobes", n_strobe, 64);
        check_val("busy_violations", busy_viol, 0);
        compare_ref("busy_frame_eq");

        // Restart request and wall change mid-frame must not disturb the frame.
        run_frame(1'b0, 1'b0, 10, 5, -1);
        check_val("restart_strobes", n_strobe, 64);
        check_val("restart_done_count", n_done, 1);
        check_val("snapshot_p31", frame[11], 8'h00);
        compare_ref("snapshot_frame_eq");
        v_walls = 2'b00;

        // Reset in the middle of a frame.
        run_frame(1'b0, 1'b0, -1, -1, 20);
        check_val("rst_strobes", n_strobe, 20);
        check_val("rst_no_done", n_done, 0);
        check_val("rst_idle_busy", busy1, 0);

        // Next frame after the reset is complete and correct.
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check_val("recover_strobes", n_strobe, 64);
        compare_ref("recover_frame_eq");

`ifdef SCENE_FOOD_EN
        food = 4'b0001;
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check_val("food_pixel", frame[18], food_rgb_v[23:16]);
        check_val("food_outside_sq", frame[9], 8'h00);
        check_val("food_other_tile", frame[22], 8'h00);
        food = 4'b0000;
`else
        check_val("food_rgb_const", {8'h00, food_rgb_v}, {8'h00, FOOD_RGB});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
